// File: rtl/pe_stream_ctrl.sv
// Upstream driver and result collector for the DSP-cascade convolution PE.
// Streams weights/samples into the PE gap-free and re-times o_P into full-window results.
module pe_stream_ctrl #(
   parameter int         KERNEL_SIZE = 4,
   parameter int         DATA_W      = 30,
   parameter int         WEIGHT_W    = 18,
   parameter int         P_W         = 48,
   parameter int         PE_LATENCY  = 6,
   parameter logic [8:0] OPMODE_RUN  = 9'b000110101,
   parameter logic [4:0] INMODE_RUN  = 5'b00100
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_w_valid,
   input  logic [KERNEL_SIZE*WEIGHT_W-1:0] i_w_data,
   output logic                            o_w_ready,
   input  logic                            i_fm_valid,
   input  logic [DATA_W-1:0]               i_fm_data,
   input  logic                            i_fm_last,
   output logic                            o_fm_ready,
   output logic [8:0]                      o_pe_opmode,
   output logic [4:0]                      o_pe_inmode,
   output logic [DATA_W-1:0]               o_pe_datafm,
   output logic [KERNEL_SIZE*WEIGHT_W-1:0] o_pe_weight,
   output logic [26:0]                     o_pe_d,
   input  logic [P_W-1:0]                  i_pe_p,
   output logic                            o_res_valid,
   output logic [P_W-1:0]                  o_res_data,
   output logic                            o_res_last,
   output logic [1:0]                      o_err
);

   localparam int WB     = KERNEL_SIZE * WEIGHT_W;
   localparam int FW     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int DW     = (PE_LATENCY > 0) ? $clog2(PE_LATENCY + 1) : 1;
   localparam int STAGES = PE_LATENCY + 1;
   localparam logic [FW-1:0] FILL_MAX  = FW'(KERNEL_SIZE - 1);
   localparam logic [DW-1:0] DRAIN_MAX = DW'(PE_LATENCY);

   typedef enum logic [1:0] {S_NOW, S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t              state_q, state_d;
   logic                wv_q, wv_d;
   logic [WB-1:0]       w_q, w_d;
   logic [DATA_W-1:0]   fm_q, fm_d;
   logic [FW-1:0]       fill_q, fill_d;
   logic [FW-1:0]       frm_q, frm_d;
   logic [DW-1:0]       drn_q, drn_d;
   logic [1:0]          err_q, err_d;
   logic [STAGES:0]     vld_pipe_q, lst_pipe_q;
   logic [P_W-1:0]      res_q;

   logic w_rdy, fm_rdy, w_hs, fm_hs, full;

   assign w_rdy  = (state_q == S_NOW) || (state_q == S_IDLE);
   assign fm_rdy = (state_q == S_IDLE) || (state_q == S_RUN);
   assign w_hs   = i_w_valid && w_rdy;
   assign fm_hs  = i_fm_valid && fm_rdy;
   assign full   = fm_hs && (fill_q == FILL_MAX);

   always_comb begin
      state_d = state_q;
      wv_d    = wv_q;
      w_d     = w_q;
      fm_d    = '0;
      fill_d  = fill_q;
      frm_d   = frm_q;
      drn_d   = drn_q;
      err_d   = err_q;

      if (w_hs) begin
         w_d  = i_w_data;
         wv_d = 1'b1;
      end

      // Fill counts the samples since the last bubble; frm counts the whole frame.
      if (fm_hs) begin
         fm_d   = i_fm_data;
         fill_d = full ? FILL_MAX : fill_q + FW'(1);
         frm_d  = (frm_q == FILL_MAX) ? FILL_MAX : frm_q + FW'(1);
         if (i_fm_last) begin
            fill_d = '0;
            frm_d  = '0;
            drn_d  = '0;
            if (frm_q != FILL_MAX) err_d[1] = 1'b1;
         end
      end

      case (state_q)
         S_NOW: begin
            if (w_hs) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (fm_hs) state_d = i_fm_last ? S_DRAIN : S_RUN;
         end
         S_RUN: begin
            if (fm_hs && i_fm_last) state_d = S_DRAIN;
            // The PE cannot stall, so a gap poisons the in-flight window.
            if (!i_fm_valid) begin
               err_d[0] = 1'b1;
               fill_d   = '0;
            end
         end
         S_DRAIN: begin
            if (drn_q == DRAIN_MAX) state_d = S_IDLE;
            else                    drn_d   = drn_q + DW'(1);
         end
         default: state_d = S_NOW;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_NOW;
         wv_q       <= 1'b0;
         w_q        <= '0;
         fm_q       <= '0;
         fill_q     <= '0;
         frm_q      <= '0;
         drn_q      <= '0;
         err_q      <= '0;
         vld_pipe_q <= '0;
         lst_pipe_q <= '0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         wv_q       <= wv_d;
         w_q        <= w_d;
         fm_q       <= fm_d;
         fill_q     <= fill_d;
         frm_q      <= frm_d;
         drn_q      <= drn_d;
         err_q      <= err_d;
         vld_pipe_q <= {vld_pipe_q[STAGES-1:0], full};
         lst_pipe_q <= {lst_pipe_q[STAGES-1:0], full && i_fm_last};
         res_q      <= i_pe_p;
      end
   end

   assign o_w_ready   = w_rdy;
   assign o_fm_ready  = fm_rdy;
   assign o_pe_opmode = wv_q ? OPMODE_RUN : 9'd0;
   assign o_pe_inmode = wv_q ? INMODE_RUN : 5'd0;
   assign o_pe_datafm = fm_q;
   assign o_pe_weight = w_q;
   assign o_pe_d      = '0;
   assign o_res_valid = vld_pipe_q[STAGES];
   assign o_res_last  = lst_pipe_q[STAGES];
   assign o_res_data  = res_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Directed bench for pe_stream_ctrl with a behavioural 6-cycle convolution PE.
module tb_pe_stream_ctrl;

   localparam int K   = 4;
   localparam int DW  = 30;
   localparam int WW  = 18;
   localparam int PW  = 48;
   localparam int LAT = 6;
   localparam logic [8:0] OPM = 9'b000110101;
   localparam logic [4:0] INM = 5'b00100;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_w_valid;
   logic [K*WW-1:0]   i_w_data;
   logic              o_w_ready;
   logic              i_fm_valid;
   logic [DW-1:0]     i_fm_data;
   logic              i_fm_last;
   logic              o_fm_ready;
   logic [8:0]        o_pe_opmode;
   logic [4:0]        o_pe_inmode;
   logic [DW-1:0]     o_pe_datafm;
   logic [K*WW-1:0]   o_pe_weight;
   logic [26:0]       o_pe_d;
   logic [PW-1:0]     i_pe_p;
   logic              o_res_valid;
   logic [PW-1:0]     o_res_data;
   logic              o_res_last;
   logic [1:0]        o_err;

   pe_stream_ctrl #(.KERNEL_SIZE(K), .DATA_W(DW), .WEIGHT_W(WW), .P_W(PW),
                    .PE_LATENCY(LAT), .OPMODE_RUN(OPM), .INMODE_RUN(INM)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_w_valid(i_w_valid), .i_w_data(i_w_data), .o_w_ready(o_w_ready),
      .i_fm_valid(i_fm_valid), .i_fm_data(i_fm_data), .i_fm_last(i_fm_last),
      .o_fm_ready(o_fm_ready), .o_pe_opmode(o_pe_opmode), .o_pe_inmode(o_pe_inmode),
      .o_pe_datafm(o_pe_datafm), .o_pe_weight(o_pe_weight), .o_pe_d(o_pe_d),
      .i_pe_p(i_pe_p), .o_res_valid(o_res_valid), .o_res_data(o_res_data),
      .o_res_last(o_res_last), .o_err(o_err));

   always #5 i_clk = ~i_clk;

   // Behavioural PE: y = sum w[j]*x[k-j], visible PE_LATENCY clocks after x[k].
   logic signed [DW-1:0] hreg [K-1];
   logic signed [63:0]   acc;
   logic signed [63:0]   xv;
   logic [PW-1:0]        pp [LAT];

   always_comb begin
      acc = '0;
      xv  = '0;
      for (int j = 0; j < K; j++) begin
         xv  = (j == 0) ? 64'($signed(o_pe_datafm)) : 64'(hreg[(j == 0) ? 0 : j - 1]);
         acc = acc + 64'($signed(o_pe_weight[j*WW +: WW])) * xv;
      end
   end

   always @(posedge i_clk) begin
      hreg[0] <= o_pe_datafm;
      for (int j = 1; j < K - 1; j++) hreg[j] <= hreg[j-1];
      pp[0] <= acc[PW-1:0];
      for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
   end
   assign i_pe_p = pp[LAT-1];

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   logic [PW-1:0] res_q [$];
   bit            last_q [$];
   int            first_cyc = -1;

   always @(negedge i_clk) begin
      if (o_res_valid) begin
         res_q.push_back(o_res_data);
         last_q.push_back(o_res_last);
         if (first_cyc < 0) first_cyc = cyc;
      end
   end

   int errors = 0;
   int checks = 0;
   int hs4;
   int dc;
   int rdy_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Stream samples 1..n; an optional one-cycle gap before sample gap+1; stop>0 halts early.
   task automatic run_frame(input int n, input int gap, input int stop);
      for (int k = 1; k <= n; k++) begin
         if (gap > 0 && k - 1 == gap) begin
            i_fm_valid = 1'b0;
            @(negedge i_clk);
         end
         i_fm_valid = 1'b1;
         i_fm_data  = DW'(k);
         i_fm_last  = (k == n);
         if (k == 4) hs4 = cyc;
         @(negedge i_clk);
         i_w_valid = 1'b0;
         if (stop > 0 && k == stop) break;
      end
      i_fm_valid = 1'b0;
      i_fm_last  = 1'b0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (!o_fm_ready && cnt < 50) begin
         cnt++;
         @(negedge i_clk);
      end
   endtask

   task automatic clear_q();
      res_q.delete();
      last_q.delete();
      first_cyc = -1;
   endtask

   localparam logic [K*WW-1:0] W1 = {18'd2, 18'd1, 18'd2, 18'd1};
   localparam logic [K*WW-1:0] W2 = {18'd1, 18'd1, 18'd1, 18'd1};
   int exp_gap [10] = '{14, 20, 26, 50, 56, 62, 68, 74, 80, 86};

   initial begin
      i_rst = 1'b1; i_w_valid = 1'b0; i_w_data = '0;
      i_fm_valid = 1'b0; i_fm_data = '0; i_fm_last = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("rst_w_ready",  64'(o_w_ready),   64'(1));
      chk("rst_fm_ready", 64'(o_fm_ready),  64'(0));
      chk("rst_opmode",   64'(o_pe_opmode), 64'(0));
      chk("rst_inmode",   64'(o_pe_inmode), 64'(0));
      chk("rst_res",      64'({o_res_valid, o_res_last}), 64'(0));
      chk("rst_res_data", 64'(o_res_data),  64'(0));
      chk("rst_err",      64'(o_err),       64'(0));
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("now_fm_ready", 64'(o_fm_ready),  64'(0));

      // weight load
      i_w_valid = 1'b1; i_w_data = W1;
      @(negedge i_clk);
      i_w_valid = 1'b0;
      chk("w_opmode",   64'(o_pe_opmode), 64'(OPM));
      chk("w_inmode",   64'(o_pe_inmode), 64'(INM));
      chk("w_weight",   64'(o_pe_weight[63:0]), 64'(W1[63:0]));
      chk("w_fm_ready", 64'(o_fm_ready),  64'(1));
      chk("pe_d",       64'(o_pe_d),      64'(0));

      // frame 1..16, no gaps
      clear_q();
      run_frame(16, 0, 0);
      wait_idle(dc);
      chk("f1_drain", 64'(dc), 64'(7));
      repeat (2) @(negedge i_clk);
      chk("f1_count", 64'(res_q.size()), 64'(13));
      chk("f1_latency", 64'(first_cyc - hs4), 64'(8));
      for (int i = 0; i < res_q.size() && i < 13; i++) begin
         chk("f1_data", 64'(res_q[i]), 64'(14 + 6*i));
         chk("f1_last", 64'(last_q[i]), 64'(i == 12));
      end
      chk("f1_err", 64'(o_err), 64'(0));

      // frame with a bubble after sample 6
      clear_q();
      run_frame(16, 6, 0);
      wait_idle(dc);
      repeat (2) @(negedge i_clk);
      chk("f2_count", 64'(res_q.size()), 64'(10));
      for (int i = 0; i < res_q.size() && i < 10; i++) begin
         chk("f2_data", 64'(res_q[i]), 64'(exp_gap[i]));
         chk("f2_last", 64'(last_q[i]), 64'(i == 9));
      end
      chk("f2_err", 64'(o_err), 64'(1));

      // short frame
      clear_q();
      run_frame(3, 0, 0);
      wait_idle(dc);
      chk("f3_drain", 64'(dc), 64'(7));
      repeat (2) @(negedge i_clk);
      chk("f3_count", 64'(res_q.size()), 64'(0));
      chk("f3_err",   64'(o_err), 64'(3));

      // weight load coincident with the first sample
      clear_q();
      i_w_valid = 1'b1; i_w_data = W2;
      run_frame(4, 0, 0);
      wait_idle(dc);
      repeat (2) @(negedge i_clk);
      chk("f4_count", 64'(res_q.size()), 64'(1));
      if (res_q.size() > 0) begin
         chk("f4_data", 64'(res_q[0]),  64'(10));
         chk("f4_last", 64'(last_q[0]), 64'(1));
      end

      // reset in the middle of a frame
      clear_q();
      run_frame(16, 0, 5);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("mr_w_ready",  64'(o_w_ready),   64'(1));
      chk("mr_fm_ready", 64'(o_fm_ready),  64'(0));
      chk("mr_opmode",   64'(o_pe_opmode), 64'(0));
      chk("mr_datafm",   64'(o_pe_datafm), 64'(0));
      chk("mr_weight",   64'(o_pe_weight[63:0]), 64'(0));
      chk("mr_res_data", 64'(o_res_data),  64'(0));
      chk("mr_err",      64'(o_err),       64'(0));
      i_rst = 1'b0;
      i_fm_valid = 1'b1; i_fm_data = DW'(99);
      rdy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge i_clk);
         if (o_fm_ready) rdy_cnt++;
      end
      i_fm_valid = 1'b0;
      chk("mr_no_ready",   64'(rdy_cnt), 64'(0));
      chk("mr_no_results", 64'(res_q.size()), 64'(0));
      i_w_valid = 1'b1; i_w_data = W1;
      @(negedge i_clk);
      i_w_valid = 1'b0;
      chk("mr_reload_ready", 64'(o_fm_ready), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_stream_ctrl.md
Name: pe_stream_ctrl

Overview:
Upstream driver and result collector for the DSP-cascade PE (1-D convolution, KERNEL_SIZE taps).
- Accepts kernel weights and feature-map frames over valid/ready handshakes.
- Drives the PE's OPMODE/INMODE/DataFM/Weight/D inputs as a gap-free stream.
- Re-times o_P by the PE latency and emits only full-window results, with valid and last flags.
- Sits between the line-buffer/feature-map fetch logic and the PE.

Parameters:
KERNEL_SIZE, 4, number of taps / cascaded DSPs in the PE
DATA_W, 30, feature-map sample width (PE A port)
WEIGHT_W, 18, per-tap weight width; the weight bus is KERNEL_SIZE*WEIGHT_W
P_W, 48, PE accumulator output width
PE_LATENCY, 6, clocks from o_pe_datafm update to the matching i_pe_p
OPMODE_RUN, 9'b000110101, OPMODE driven while weights are valid
INMODE_RUN, 5'b00100, INMODE driven while weights are valid

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_w_valid  in  1  weight-load request
i_w_data  in  KERNEL_SIZE*WEIGHT_W  weights; tap j at bits [j*WEIGHT_W +: WEIGHT_W]
o_w_ready  out  1  weight-load accept
i_fm_valid  in  1  feature-map sample valid
i_fm_data  in  DATA_W  signed sample
i_fm_last  in  1  last sample of frame
o_fm_ready  out  1  sample accept
o_pe_opmode  out  9  to PE OPMODE
o_pe_inmode  out  5  to PE INMODE
o_pe_datafm  out  DATA_W  to PE i_DataFM
o_pe_weight  out  KERNEL_SIZE*WEIGHT_W  to PE i_Weight
o_pe_d  out  27  to PE i_D; constant 0
i_pe_p  in  P_W  from PE o_P
o_res_valid  out  1  full-window result valid
o_res_data  out  P_W  signed result
o_res_last  out  1  last result of frame
o_err  out  2  sticky; bit0 = mid-frame bubble, bit1 = short frame

Behaviour:
- Reset values: all outputs 0; state S_NOW; weights invalid; fill counter 0; valid/last delay lines cleared. Reset mid-frame aborts the frame, no result is emitted, and new weights are required.
- States and handshakes:
  - S_NOW: o_w_ready=1, o_fm_ready=0. A handshake latches i_w_data into o_pe_weight, then goes to S_IDLE.
  - S_IDLE: o_w_ready=1, o_fm_ready=1. A weight handshake reloads weights. A sample handshake goes to S_RUN. If both handshake in the same cycle, the sample uses the new weights (both registered on the same edge).
  - S_RUN: o_w_ready=0, o_fm_ready=1. Each accepted sample appears on o_pe_datafm on the handshake edge. A handshake with i_fm_last goes to S_DRAIN.
  - S_DRAIN: both readies 0. o_pe_datafm=0 for PE_LATENCY+1 cycles, then S_IDLE.
- OPMODE/INMODE: o_pe_opmode/o_pe_inmode = OPMODE_RUN/INMODE_RUN whenever weights are valid, 0 in S_NOW. o_pe_d is always 0.
- Idle cycles: in S_IDLE, and in S_RUN when i_fm_valid=0, o_pe_datafm is driven to 0.
- Bubbles: the PE has no clock enable. A cycle in S_RUN with i_fm_valid=0 sets o_err[0] and resets the fill counter to 0.
- Fill counter: saturates at KERNEL_SIZE-1. A sample accepted while the counter equals KERNEL_SIZE-1 is a full window; it pushes 1 into the valid delay line, otherwise 0. The last flag is pushed in parallel.
- Result alignment: o_res_data is a register of i_pe_p. o_res_valid/o_res_last assert exactly PE_LATENCY+1 cycles after the sample's handshake edge.
- Result content: result k = sum over j of w[j]*x[k-j], j = 0..KERNEL_SIZE-1. A frame of N >= KERNEL_SIZE samples yields N-KERNEL_SIZE+1 results; o_res_last is on the last one.
- Short frame: N < KERNEL_SIZE sets o_err[1] and emits no result and no last.
- Downstream backpressure: none; results are always accepted.
- o_err bits clear only on reset.

Test Plan:
All scenarios use a behavioural PE model with PE_LATENCY=6.
- Reset then idle: o_w_ready=1, o_fm_ready=0, o_pe_opmode=0, all results 0.
- Load weights {w3,w2,w1,w0}={2,1,2,1}; stream 1..16, last on 16, no gaps -> 13 results 14,20,26,...,86. First result 7 cycles after the handshake of sample 4; o_res_last only with 86; 7 drain cycles then o_fm_ready=1.
- Same frame with i_fm_valid low for 1 cycle after sample 6 -> o_err[0]=1. No results for the next 3 samples after the gap; resumes with full windows of post-gap samples.
- Frame of 3 samples (1,2,3,last) -> o_err[1]=1, zero o_res_valid pulses, returns to S_IDLE.
- In S_IDLE, weight load {1,1,1,1} in the same cycle as sample 1 of 1..4 -> single result 10 with last.
- Assert i_rst mid-S_RUN -> next cycle all outputs 0, state S_NOW, pending results suppressed, o_fm_ready=0 until weights are reloaded.
